fill_arbiter: RTL and testbench
===============================

// Module: fill_arbiter
// PURPOSE
//  Shares one hot-water inlet valve among N_MACHINES washer controllers in a laundromat cluster.
//  Each washer raises req during its fill stage. The arbiter grants the valve to one washer at a time:
//  - selection is round-robin;
//  - each grant is bounded by a fill timeout;
//  - a valve-off dead time separates consecutive grants.
//  Sits between the per-machine stage FSMs and the physical valve driver.
// PARAMETERS
//  N_MACHINES      4   number of requesting washers (2..8)
//  MAX_FILL_CYCLES 16  max cycles a grant may be held before forced release (>=2)
//  GAP_CYCLES      2   valve-off dead time between grants (>=1)
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           asynchronous, active-low reset (0 = reset)
//  req        in   N_MACHINES  level request per washer, held while filling
//  release    in   N_MACHINES  1-cycle pulse: washer reports tank full
//  grant      out  N_MACHINES  one-hot (or zero) valve ownership, registered
//  grant_id   out  3           index of current owner; 0 when no grant
//  valve_on   out  1           drive to inlet valve; 1 only in GRANT state
//  timeout    out  N_MACHINES  1-cycle pulse on the owner whose grant was forced off
// BEHAVIOUR
//  Reset (async assert, sync deassert of effect):
//  - outputs: grant=0, grant_id=0, valve_on=0, timeout=0;
//  - state=IDLE, rr_ptr=0, fill_cnt=0.
//  Priority: requester search starts at rr_ptr and wraps modulo N_MACHINES.
//  Arbitration takes one cycle.
//  FSM:
//  - IDLE: if any req bit, latch winner w. Next cycle: grant[w]=1, valve_on=1, fill_cnt=1, ->GRANT.
//  - GRANT: fill_cnt increments each cycle. The grant ends on the first of:
//    a) release[w]=1 -> normal end;
//    b) req[w]=0 -> abandon, no timeout;
//    c) fill_cnt==MAX_FILL_CYCLES with neither a) nor b) -> timeout[w] pulses 1 cycle.
//    On any end: grant=0, valve_on=0 on the next edge; rr_ptr=(w+1)%N; gap_cnt=0; ->GAP.
//  - GAP: valve_on=0, grant=0 for exactly GAP_CYCLES cycles, then ->IDLE.
//    Requests seen during GAP are arbitrated in the IDLE cycle that follows.
//  Latency:
//  - req to grant: 2 cycles from IDLE (sample + register).
//  - end to next grant: GAP_CYCLES + 2 cycles.
//  Invariants:
//  - grant is always zero or one-hot.
//  - valve_on == |grant.
//  - valve_on is never 1 in two consecutive grants without a gap.
//  Boundary cases:
//  - release on a non-owner: ignored.
//  - release and count limit in the same cycle: release wins, no timeout.
//  - all req low: the arbiter stays in IDLE; rr_ptr is unchanged.
//  - single persistent requester: regranted after every gap.
//  - reset mid-GRANT: valve_on drops asynchronously; the interrupted owner gets no timeout pulse.
//  Width: fill_cnt and gap_cnt are sized by $clog2 of their parameter plus 1. The counters do not wrap.
// CONFIGURATION
//  FILL_LOCKOUT_EN defined:
//  - a washer that receives timeout is locked out and masked from arbitration until its req is seen low for >=1 cycle;
//  - one lockout bit per machine, cleared on reset.
//  FILL_LOCKOUT_EN undefined:
//  - no lockout logic;
//  - a timed-out washer is eligible again under normal round-robin.
// TESTING
//  1. reset low, then high; req=4'b0100 -> grant=4'b0100, grant_id=2, valve_on=1 two cycles after req.
//  2. req=4'b1111 from IDLE, rr_ptr=0, release each owner after 3 cycles -> grant order 0,1,2,3,0; 2-cycle gaps between grants.
//  3. req[1] held, no release -> timeout[1] pulses on cycle 16 of grant; valve_on=0 the next cycle; GAP, then regrant to 1 (lockout off).
//  4. FILL_LOCKOUT_EN: repeat test 3 with req[3] also high -> 3 is granted after the gap; 1 is not granted until req[1] toggles low/high.
//  5. release[w] and count limit coincide at cycle 16 -> no timeout pulse; normal end.
//  6. reset driven low mid-GRANT -> grant=0, valve_on=0 immediately (async); after release, rr_ptr=0 and req=4'b0011 grants machine 0.

Source files
------------

// File: rtl/fill_arbiter.sv
// -----------------------------------------------------------------------------
// fill_arbiter
//
// Shares one hot-water inlet valve among N_MACHINES washer controllers.
// Requests are served round-robin. Each grant is bounded by a fill timeout,
// and a valve-off dead time separates consecutive grants.
//
// Flow: IDLE samples the requests and latches a winner. ARB registers the
// grant, so a request shows up as a grant two cycles later. GRANT holds the
// valve until the owner releases, abandons or hits the fill limit. GAP keeps
// the valve off for GAP_CYCLES cycles.
//
// Parameters:
//   N_MACHINES      number of requesting washers (2..8)
//   MAX_FILL_CYCLES cycles a grant may be held before it is forced off (>=2)
//   GAP_CYCLES      valve-off dead time between grants (>=1)
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset (0 = reset)
//   req            level request per washer, held while filling
//   release_pulse  1-cycle "tank full" pulse per washer. The natural name
//                  "release" is a reserved word in SystemVerilog.
//   grant          registered one-hot (or zero) valve ownership
//   grant_id       index of the current owner, 0 when nothing is granted
//   valve_on       inlet valve drive, high only while a grant is held
//   timeout        1-cycle pulse on the owner in the last cycle of a grant
//                  that is being forced off. It is asserted alongside the
//                  still-open valve so that a release arriving in the same
//                  cycle can suppress it.
//
// Optional feature (macro FILL_LOCKOUT_EN):
//   A washer that times out is masked from arbitration until its req has
//   been seen low for at least one cycle. Without the macro, a timed-out
//   washer stays eligible under normal round-robin.
// -----------------------------------------------------------------------------
module fill_arbiter #(
    parameter int N_MACHINES      = 4,
    parameter int MAX_FILL_CYCLES = 16,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_MACHINES-1:0] req,
    input  logic [N_MACHINES-1:0] release_pulse,
    output logic [N_MACHINES-1:0] grant,
    output logic [2:0]            grant_id,
    output logic                  valve_on,
    output logic [N_MACHINES-1:0] timeout
);

    localparam int PTR_W  = $clog2(N_MACHINES);
    localparam int FILL_W = $clog2(MAX_FILL_CYCLES) + 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        GRANT,
        GAP
    } state_t;

    state_t                  state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        owner;
    logic [PTR_W-1:0]        winner;
    logic [PTR_W-1:0]        next_ptr;
    logic [PTR_W-1:0]        cand;
    logic [FILL_W-1:0]       fill_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic [N_MACHINES-1:0]   eligible;
    logic [N_MACHINES-1:0]   owner_onehot;
    logic                    found;
    logic                    owner_req;
    logic                    owner_release;
    logic                    fill_limit;
    logic                    grant_end;
    logic                    forced_off;

`ifdef FILL_LOCKOUT_EN
    logic [N_MACHINES-1:0]   lockout;

    // A lockout bit is set by a timeout and is held only while req stays
    // high. One low cycle on req clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lockout <= '0;
        end else begin
            lockout <= req & (lockout | timeout);
        end
    end

    assign eligible = req & ~lockout;
`else
    assign eligible = req;
`endif

    // Round-robin search starting at rr_ptr and wrapping modulo N_MACHINES.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < N_MACHINES; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % N_MACHINES);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        owner_onehot        = '0;
        owner_onehot[owner] = 1'b1;
    end

    assign owner_req     = req[owner];
    assign owner_release = release_pulse[owner];
    assign fill_limit    = (fill_cnt == FILL_W'(MAX_FILL_CYCLES));
    assign grant_end     = (state == GRANT) && (owner_release || !owner_req || fill_limit);

    // A release or an abandon in the limit cycle takes precedence, so the
    // forced-off condition excludes both.
    assign forced_off    = (state == GRANT) && fill_limit && owner_req && !owner_release;
    assign timeout       = forced_off ? owner_onehot : '0;

    assign next_ptr      = (owner == PTR_W'(N_MACHINES - 1)) ? '0 : owner + 1'b1;

    // Main controller. Grant outputs are registered and change only on
    // ARB -> GRANT and on the end of a grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            fill_cnt <= '0;
            gap_cnt  <= '0;
            grant    <= '0;
            grant_id <= '0;
            valve_on <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= winner;
                        state <= ARB;
                    end
                end
                ARB: begin
                    grant    <= owner_onehot;
                    grant_id <= 3'(owner);
                    valve_on <= 1'b1;
                    fill_cnt <= FILL_W'(1);
                    state    <= GRANT;
                end
                GRANT: begin
                    if (grant_end) begin
                        grant    <= '0;
                        grant_id <= '0;
                        valve_on <= 1'b0;
                        fill_cnt <= '0;
                        rr_ptr   <= next_ptr;
                        gap_cnt  <= '0;
                        state    <= GAP;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fill_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fill_arbiter
//
// Self-checking bench for fill_arbiter. A reference model tracks the current
// owner, how long the grant has been held, how many dead cycles remain before
// the next arbitration, and which winner is waiting to be granted. The DUT
// outputs are compared with this model every cycle. Directed scenarios are
// followed by randomized request and release traffic.
// -----------------------------------------------------------------------------
module tb_fill_arbiter;

    localparam int N    = 4;
    localparam int MAXF = 16;
    localparam int GAPC = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   release_pulse = '0;
    logic [N-1:0]   grant;
    logic [2:0]     grant_id;
    logic           valve_on;
    logic [N-1:0]   timeout;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    int             m_owner;
    int             m_pending;
    int             m_held;
    int             m_cool;
    int             m_ptr;
    logic [N-1:0]   m_lock;
    logic [N-1:0]   obs_timeout;

    fill_arbiter #(
        .N_MACHINES(N),
        .MAX_FILL_CYCLES(MAXF),
        .GAP_CYCLES(GAPC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .release_pulse(release_pulse),
        .grant(grant),
        .grant_id(grant_id),
        .valve_on(valve_on),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v = N'(1) << i;
        return v;
    endfunction

    function automatic logic [N-1:0] expTimeout(input logic [N-1:0] r, input logic [N-1:0] rel);
        logic [N-1:0] o;
        o = onehot(m_owner);
        if (m_owner >= 0 && m_held == MAXF && (r & o) != 0 && (rel & o) == 0)
            return o;
        return '0;
    endfunction

    function automatic void modelReset();
        m_owner   = -1;
        m_pending = -1;
        m_held    = 0;
        m_cool    = 0;
        m_ptr     = 0;
        m_lock    = '0;
    endfunction

    // Advances the model by one rising edge with the inputs present before it.
    function automatic void modelStep(input logic [N-1:0] r, input logic [N-1:0] rel);
        logic [N-1:0] fired;
        logic [N-1:0] o;
        fired = expTimeout(r, rel);
        if (m_owner >= 0) begin
            o = onehot(m_owner);
            if ((rel & o) != 0 || (r & o) == 0 || m_held == MAXF) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_held  = 0;
                m_cool  = GAPC;
            end else begin
                m_held++;
            end
        end else if (m_pending >= 0) begin
            m_owner   = m_pending;
            m_pending = -1;
            m_held    = 1;
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            for (int k = 0; k < N; k++) begin
                if ((r & ~m_lock & onehot((m_ptr + k) % N)) != 0) begin
                    m_pending = (m_ptr + k) % N;
                    break;
                end
            end
        end
`ifdef FILL_LOCKOUT_EN
        m_lock = r & (m_lock | fired);
`else
        m_lock = '0 & fired;
`endif
    endfunction

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] rel);
        @(negedge clk);
        req = r;
        release_pulse = rel;
        #1;
        obs_timeout = timeout;
        checkOutput("grant", 32'(grant), 32'(onehot(m_owner)));
        checkOutput("grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        checkOutput("valve_on", 32'(valve_on), (m_owner >= 0) ? 32'd1 : 32'd0);
        checkOutput("timeout", 32'(timeout), 32'(expTimeout(r, rel)));
        checkOutput("onehot0", 32'($onehot0(grant)), 32'd1);
        @(posedge clk);
        modelStep(r, rel);
    endtask

    task automatic doReset();
        @(negedge clk);
        #3;
        reset = 1'b0;
        req = '0;
        release_pulse = '0;
        #1;
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
        checkOutput("rst_valve", 32'(valve_on), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        modelStep(req, release_pulse);
    endtask

    initial begin
        int order[$];
        int gaps[$];
        int offcnt;
        logic [N-1:0] prev;
        logic [N-1:0] rel;
        logic [N-1:0] rcur;

        modelReset();

        // Test 1: single request, two-cycle grant latency
        doReset();
        applyStimulus(4'b0100, '0);
        #1;
        checkOutput("t1_not_yet", 32'(grant), 32'd0);
        applyStimulus(4'b0100, '0);
        #1;
        checkOutput("t1_grant", 32'(grant), 32'b0100);
        checkOutput("t1_grant_id", 32'(grant_id), 32'd2);
        checkOutput("t1_valve", 32'(valve_on), 32'd1);
        applyStimulus(4'b0100, 4'b0100);

        // Test 2: all requesting, each owner releases after 3 grant cycles
        doReset();
        prev = '0;
        offcnt = 0;
        for (int cyc = 0; cyc < 80 && order.size() < 5; cyc++) begin
            rel = (m_owner >= 0 && m_held == 3) ? onehot(m_owner) : '0;
            applyStimulus(4'b1111, rel);
            #1;
            if (grant != 0 && prev == 0) begin
                order.push_back(int'(grant_id));
                if (order.size() > 1) gaps.push_back(offcnt);
                offcnt = 0;
            end
            if (grant == 0) offcnt++;
            prev = grant;
        end
        checkOutput("t2_count", 32'(order.size()), 32'd5);
        foreach (order[i]) checkOutput("t2_order", 32'(order[i]), 32'(i % N));
        foreach (gaps[i]) checkOutput("t2_gap", 32'(gaps[i]), 32'(GAPC + 2));

        // Test 3: held request with no release is forced off at the limit
        doReset();
        applyStimulus(4'b0010, '0);
        applyStimulus(4'b0010, '0);
        for (int k = 1; k <= MAXF; k++) begin
            applyStimulus(4'b0010, '0);
            if (k == MAXF - 1) checkOutput("t3_no_early", 32'(obs_timeout), 32'd0);
        end
        checkOutput("t3_timeout", 32'(obs_timeout), 32'b0010);
        #1;
        checkOutput("t3_valve_off", 32'(valve_on), 32'd0);
        for (int j = 0; j < GAPC + 2; j++) applyStimulus(4'b0010, '0);
        #1;
`ifdef FILL_LOCKOUT_EN
        checkOutput("t3_regrant", 32'(grant), 32'd0);
`else
        checkOutput("t3_regrant", 32'(grant), 32'b0010);
`endif

        // Test 4: timeout on 1 with 3 also requesting
        doReset();
        applyStimulus(4'b1010, '0);
        applyStimulus(4'b1010, '0);
        for (int k = 1; k <= MAXF; k++) applyStimulus(4'b1010, '0);
        checkOutput("t4_timeout", 32'(obs_timeout), 32'b0010);
        for (int j = 0; j < GAPC + 2; j++) applyStimulus(4'b1010, '0);
        #1;
        checkOutput("t4_next_owner", 32'(grant), 32'b1000);
        applyStimulus(4'b1010, 4'b1000);
        for (int j = 0; j < GAPC + 2; j++) applyStimulus(4'b0010, '0);
        #1;
`ifdef FILL_LOCKOUT_EN
        checkOutput("t4_locked", 32'(grant), 32'd0);
        applyStimulus(4'b0000, '0);
        applyStimulus(4'b0010, '0);
        applyStimulus(4'b0010, '0);
        #1;
        checkOutput("t4_unlocked", 32'(grant), 32'b0010);
`else
        checkOutput("t4_eligible", 32'(grant), 32'b0010);
`endif

        // Test 5: release coincides with the fill limit
        doReset();
        applyStimulus(4'b0010, '0);
        applyStimulus(4'b0010, '0);
        for (int k = 1; k <= MAXF; k++)
            applyStimulus(4'b0010, (k == MAXF) ? 4'b0010 : 4'b0000);
        checkOutput("t5_no_timeout", 32'(obs_timeout), 32'd0);
        #1;
        checkOutput("t5_end", 32'(valve_on), 32'd0);

        // Test 6: reset in the middle of a grant restores the pointer
        doReset();
        applyStimulus(4'b0001, '0);
        applyStimulus(4'b0001, '0);
        applyStimulus(4'b0001, 4'b0001);
        for (int j = 0; j < GAPC + 2; j++) applyStimulus(4'b0010, '0);
        #1;
        checkOutput("t6_owner1", 32'(grant), 32'b0010);
        applyStimulus(4'b0010, '0);
        doReset();
        applyStimulus(4'b0011, '0);
        applyStimulus(4'b0011, '0);
        #1;
        checkOutput("t6_grant0", 32'(grant), 32'b0001);
        checkOutput("t6_grant_id", 32'(grant_id), 32'd0);

        // Randomized traffic
        rcur = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) rcur = rcur ^ onehot(b);
            rel = '0;
            if ($urandom_range(0, 4) == 0) rel = onehot(int'($urandom_range(0, N - 1)));
            if (m_owner >= 0 && $urandom_range(0, 9) == 0) rel = rel | onehot(m_owner);
            if ($urandom_range(0, 599) == 0) begin
                doReset();
                rcur = '0;
            end else begin
                applyStimulus(rcur, rel);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
